// File: rtl/alu_seq.sv
// Multi-cycle integer execution unit. Single-cycle logic/add ops, bit-serial shifts and
// an optional bit-serial unsigned multiplier built only when ALU_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       OPCODE,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic [WIDTH-1:0] RESULT,
    output logic             WRITE
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_XOR = 3'b100, OP_SLL = 3'b101, OP_SRL = 3'b110, OP_MUL = 3'b111
    } op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             write_q, write_d;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] shifted;
    op_t              op;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] sum;
`endif

    assign op      = op_t'(OPCODE);
    assign shamt   = DATA2[SW-1:0];
    assign shifted = left_q ? (acc_q << 1) : (acc_q >> 1);
`ifdef ALU_MUL_EN
    assign sum     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            result_q <= '0;
            write_q  <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            result_q <= result_d;
            write_q  <= write_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        result_d = result_q;
        write_d  = 1'b0;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    case (op)
                        OP_ADD: begin result_d = DATA1 + DATA2; write_d = 1'b1; end
                        OP_SUB: begin result_d = DATA1 - DATA2; write_d = 1'b1; end
                        OP_AND: begin result_d = DATA1 & DATA2; write_d = 1'b1; end
                        OP_OR:  begin result_d = DATA1 | DATA2; write_d = 1'b1; end
                        OP_XOR: begin result_d = DATA1 ^ DATA2; write_d = 1'b1; end
                        OP_SLL, OP_SRL: begin
                            // a zero shift amount completes like a single-cycle op
                            if (shamt == '0) begin
                                result_d = DATA1;
                                write_d  = 1'b1;
                            end else begin
                                acc_d   = DATA1;
                                cnt_d   = CW'(shamt);
                                left_d  = (op == OP_SLL);
                                state_d = SHIFT;
                            end
                        end
                        OP_MUL: begin
`ifdef ALU_MUL_EN
                            acc_d    = '0;
                            mcand_d  = DATA1;
                            mplier_d = DATA2;
                            cnt_d    = CW'(WIDTH);
                            state_d  = MUL;
`else
                            result_d = '0;
                            write_d  = 1'b1;
`endif
                        end
                    endcase
                end
            end
            SHIFT: begin
                acc_d = shifted;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = shifted;
                    write_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = sum;
                    write_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign BUSY   = (state_q != IDLE);
    assign RESULT = result_q;
    assign WRITE  = write_q;

endmodule
